// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM arbiter.
// Supplies a fallback ROM_ADDRESS_BITWIDTH when the shared define is not already set.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 16
`endif

package rom_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

endpackage

// File: rtl/rom_arb.sv
// Arbitrates fetch and load requests onto a single-port ROM; ROM_ARB_RR_EN selects round-robin over fixed LD priority.
// Latency: grant is combinational, response pulses exactly one cycle after acceptance, fully pipelined.
// Backpressure: requests stall via ready (= grant); responses have none and must be consumed on the pulse.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 16
`endif

module rom_arb
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = `ROM_ADDRESS_BITWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_req_ready,
    output logic              ld_rsp_valid,
    output logic              ld_rsp_misalign,
    output logic [WORD_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [WORD_W-1:0] rom_data
);

    logic              w_if_gnt;
    logic              w_ld_gnt;
    logic [ADDR_W-1:0] w_addr;
    owner_e            w_owner_nxt;
    logic              w_misalign_nxt;
    owner_e            r_owner;
    logic              r_misalign;
`ifdef ROM_ARB_RR_EN
    logic              r_last_ld;
    logic              w_last_ld_nxt;
`endif

    // Grants are suppressed during reset so nothing is accepted while reset_n is low.
    always_comb begin
        w_if_gnt       = 1'b0;
        w_ld_gnt       = 1'b0;
        w_addr         = '0;
        w_owner_nxt    = OWN_NONE;
        w_misalign_nxt = 1'b0;
`ifdef ROM_ARB_RR_EN
        w_last_ld_nxt  = r_last_ld;
`endif
        if (reset_n) begin
            if (if_req_valid && ld_req_valid) begin
`ifdef ROM_ARB_RR_EN
                // Only contended grants move the pointer.
                if (r_last_ld) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_ld_gnt = 1'b1;
                end
                w_last_ld_nxt = ~r_last_ld;
`else
                w_ld_gnt = 1'b1;
`endif
            end else begin
                w_if_gnt = if_req_valid;
                w_ld_gnt = ld_req_valid;
            end
        end

        if (w_ld_gnt) begin
            w_addr         = ld_req_addr;
            w_owner_nxt    = OWN_LD;
            w_misalign_nxt = |ld_req_addr[1:0];
        end else if (w_if_gnt) begin
            w_addr         = if_req_addr;
            w_owner_nxt    = OWN_IF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner    <= OWN_NONE;
            r_misalign <= 1'b0;
`ifdef ROM_ARB_RR_EN
            r_last_ld  <= 1'b0;
`endif
        end else begin
            r_owner    <= w_owner_nxt;
            r_misalign <= w_misalign_nxt;
`ifdef ROM_ARB_RR_EN
            r_last_ld  <= w_last_ld_nxt;
`endif
        end
    end

    assign if_req_ready    = w_if_gnt;
    assign ld_req_ready    = w_ld_gnt;
    assign rom_address     = w_addr;
    // A redirect kills the fetch response in the same cycle it is raised.
    assign if_rsp_valid    = (r_owner == OWN_IF) && !if_flush;
    assign ld_rsp_valid    = (r_owner == OWN_LD);
    assign ld_rsp_misalign = (r_owner == OWN_LD) && r_misalign;
    assign rsp_data        = rom_data;

endmodule

// File: tb/tb_rom_arb.sv
// Directed bench for rom_arb: reset, fetch streaming, contention, flush, load misalignment.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 16
`endif

module tb_rom_arb;

    localparam int AW = `ROM_ADDRESS_BITWIDTH;

    logic          clk;
    logic          reset_n;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_flush;
    logic          if_rsp_valid;
    logic          ld_req_valid;
    logic [AW-1:0] ld_req_addr;
    logic          ld_req_ready;
    logic          ld_rsp_valid;
    logic          ld_rsp_misalign;
    logic [31:0]   rsp_data;
    logic [AW-1:0] rom_address;
    logic [31:0]   rom_data;

    int vectors;
    int miscompares;

    rom_arb #(.ADDR_W(AW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_req_valid    (if_req_valid),
        .if_req_addr     (if_req_addr),
        .if_req_ready    (if_req_ready),
        .if_flush        (if_flush),
        .if_rsp_valid    (if_rsp_valid),
        .ld_req_valid    (ld_req_valid),
        .ld_req_addr     (ld_req_addr),
        .ld_req_ready    (ld_req_ready),
        .ld_rsp_valid    (ld_rsp_valid),
        .ld_rsp_misalign (ld_rsp_misalign),
        .rsp_data        (rsp_data),
        .rom_address     (rom_address),
        .rom_data        (rom_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM: word n holds 0xC0DE_0000 + n, registered one cycle after the address.
    always @(posedge clk) rom_data <= 32'hC0DE_0000 | 32'(rom_address >> 2);

    task automatic idle_inputs();
        if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
        ld_req_valid = 1'b0; ld_req_addr = '0;
    endtask

    task automatic test_reset();
        // Requests raised while in reset must not be accepted.
        @(negedge clk); idle_inputs();
        if_req_valid = 1'b1; if_req_addr = 16'h0010; ld_req_valid = 1'b1; ld_req_addr = 16'h0040;
        #1;
        vectors++; if (if_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_if_ready got=%b exp=0", if_req_ready); end
        vectors++; if (ld_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ld_ready got=%b exp=0", ld_req_ready); end
        vectors++; if ({if_rsp_valid, ld_rsp_valid, ld_rsp_misalign} !== 3'b000) begin miscompares++; $display("FAIL rst_rsp got=%b exp=000", {if_rsp_valid, ld_rsp_valid, ld_rsp_misalign}); end
        vectors++; if (rom_address !== 16'h0000) begin miscompares++; $display("FAIL rst_addr got=%h exp=0000", rom_address); end
        @(negedge clk); idle_inputs(); reset_n = 1'b1; #1;
        vectors++; if ({if_rsp_valid, ld_rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_first_cycle got=%b exp=00", {if_rsp_valid, ld_rsp_valid}); end
        // Fetch accepted, then reset lands before its response.
        @(negedge clk); if_req_valid = 1'b1; if_req_addr = 16'h0010; #1;
        vectors++; if (if_req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_if_ready got=%b exp=1", if_req_ready); end
        @(negedge clk); idle_inputs(); reset_n = 1'b0; #1;
        vectors++; if (if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rsp got=%b exp=0", if_rsp_valid); end
        @(negedge clk); reset_n = 1'b1; #1;
        vectors++; if ({if_rsp_valid, ld_rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL mid_release_rsp got=%b exp=00", {if_rsp_valid, ld_rsp_valid}); end
        @(negedge clk); if_req_valid = 1'b1; if_req_addr = 16'h0000; #1;
        vectors++; if (if_req_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got=%b exp=1", if_req_ready); end
        @(negedge clk); idle_inputs(); #1;
        vectors++; if (if_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_rsp got=%b exp=1", if_rsp_valid); end
        vectors++; if (rsp_data !== 32'hC0DE_0000) begin miscompares++; $display("FAIL post_rst_data got=%h exp=c0de0000", rsp_data); end
    endtask

    task automatic test_if_stream();
        logic [AW-1:0] addrs [3];
        logic [31:0]   words [3];
        addrs = '{16'h0000, 16'h0004, 16'h0008};
        words = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle_inputs();
            if (i < 3) begin if_req_valid = 1'b1; if_req_addr = addrs[i]; end
            #1;
            if (i < 3) begin
                vectors++; if (if_req_ready !== 1'b1 || rom_address !== addrs[i]) begin miscompares++; $display("FAIL stream_req%0d ready=%b addr=%h exp ready=1 addr=%h", i, if_req_ready, rom_address, addrs[i]); end
            end else begin
                vectors++; if (rom_address !== 16'h0000) begin miscompares++; $display("FAIL stream_idle_addr%0d got=%h exp=0000", i, rom_address); end
            end
            if (i >= 1 && i <= 3) begin
                vectors++; if (if_rsp_valid !== 1'b1 || rsp_data !== words[i-1]) begin miscompares++; $display("FAIL stream_rsp%0d valid=%b data=%h exp valid=1 data=%h", i-1, if_rsp_valid, rsp_data, words[i-1]); end
            end else begin
                vectors++; if (if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stream_norsp%0d got=%b exp=0", i, if_rsp_valid); end
            end
        end
    endtask

    task automatic test_contention();
        logic exp_ld [4];
`ifdef ROM_ARB_RR_EN
        exp_ld = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_ld = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle_inputs();
            if (i < 4) begin
                if_req_valid = 1'b1; if_req_addr = 16'h0020;
                ld_req_valid = 1'b1; ld_req_addr = 16'h0040;
            end
            #1;
            if (i < 4) begin
                vectors++; if (ld_req_ready !== exp_ld[i] || if_req_ready !== !exp_ld[i]) begin miscompares++; $display("FAIL cont_gnt%0d ld_rdy=%b if_rdy=%b exp ld_rdy=%b", i, ld_req_ready, if_req_ready, exp_ld[i]); end
                vectors++; if (rom_address !== (exp_ld[i] ? 16'h0040 : 16'h0020)) begin miscompares++; $display("FAIL cont_addr%0d got=%h", i, rom_address); end
            end
            if (i >= 1) begin
                vectors++; if (ld_rsp_valid !== exp_ld[i-1] || if_rsp_valid !== !exp_ld[i-1]) begin miscompares++; $display("FAIL cont_rsp%0d ld_v=%b if_v=%b exp ld_v=%b", i-1, ld_rsp_valid, if_rsp_valid, exp_ld[i-1]); end
                vectors++; if (rsp_data !== (exp_ld[i-1] ? 32'hC0DE_0010 : 32'hC0DE_0008)) begin miscompares++; $display("FAIL cont_data%0d got=%h", i-1, rsp_data); end
            end
        end
    endtask

    task automatic test_flush();
        @(negedge clk); idle_inputs(); if_req_valid = 1'b1; if_req_addr = 16'h0008; #1;
        vectors++; if (if_req_ready !== 1'b1) begin miscompares++; $display("FAIL flush_first_ready got=%b exp=1", if_req_ready); end
        @(negedge clk); if_flush = 1'b1; if_req_addr = 16'h0030; #1;
        vectors++; if (if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL flush_kill got=%b exp=0", if_rsp_valid); end
        vectors++; if (if_req_ready !== 1'b1 || rom_address !== 16'h0030) begin miscompares++; $display("FAIL flush_new_req ready=%b addr=%h exp ready=1 addr=0030", if_req_ready, rom_address); end
        @(negedge clk); idle_inputs(); #1;
        vectors++; if (if_rsp_valid !== 1'b1 || rsp_data !== 32'hC0DE_000C) begin miscompares++; $display("FAIL flush_rsp valid=%b data=%h exp valid=1 data=c0de000c", if_rsp_valid, rsp_data); end
        @(negedge clk); #1;
        vectors++; if (if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL flush_tail got=%b exp=0", if_rsp_valid); end
    endtask

    task automatic test_misalign();
        @(negedge clk); idle_inputs(); ld_req_valid = 1'b1; ld_req_addr = 16'h0006; #1;
        vectors++; if (ld_req_ready !== 1'b1 || rom_address !== 16'h0006) begin miscompares++; $display("FAIL mis_req ready=%b addr=%h exp ready=1 addr=0006", ld_req_ready, rom_address); end
        // Flush in the response cycle must leave the load untouched.
        @(negedge clk); if_flush = 1'b1; ld_req_addr = 16'h000C; #1;
        vectors++; if (ld_rsp_valid !== 1'b1 || ld_rsp_misalign !== 1'b1) begin miscompares++; $display("FAIL mis_rsp valid=%b misalign=%b exp 1 1", ld_rsp_valid, ld_rsp_misalign); end
        vectors++; if (rsp_data !== 32'hC0DE_0001 || if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mis_data data=%h if_v=%b exp data=c0de0001 if_v=0", rsp_data, if_rsp_valid); end
        vectors++; if (ld_req_ready !== 1'b1) begin miscompares++; $display("FAIL mis_flush_ld_ready got=%b exp=1", ld_req_ready); end
        @(negedge clk); idle_inputs(); #1;
        vectors++; if (ld_rsp_valid !== 1'b1 || ld_rsp_misalign !== 1'b0 || rsp_data !== 32'hC0DE_0003) begin miscompares++; $display("FAIL aligned_rsp valid=%b misalign=%b data=%h exp 1 0 c0de0003", ld_rsp_valid, ld_rsp_misalign, rsp_data); end
        @(negedge clk); #1;
        vectors++; if (ld_rsp_valid !== 1'b0 || ld_rsp_misalign !== 1'b0) begin miscompares++; $display("FAIL ld_tail valid=%b misalign=%b exp 0 0", ld_rsp_valid, ld_rsp_misalign); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        test_reset();
        test_if_stream();
        test_contention();
        test_flush();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
